// File: rtl/ahb_slave_decoder_if.sv
// AHB address-decode bundle between the bus fabric and the slave decoder.
// The bus side drives the address phase; the decoder returns selects and default-slave response.
interface ahb_slave_decoder_if #(
  parameter int SLAVE_NUM = 4,
  parameter int ADDR_W    = 32
);
  logic [ADDR_W-1:0]    HADDR;
  logic [1:0]           HTRANS;
  logic                 HREADY;
  logic [SLAVE_NUM-1:0] HSEL;
  logic [SLAVE_NUM:0]   dp_sel;
  logic                 def_hreadyout;
  logic                 def_hresp;
  logic [7:0]           err_count;

  modport master (
    output HADDR, HTRANS, HREADY,
    input  HSEL, dp_sel, def_hreadyout, def_hresp, err_count
  );

  modport slave (
    input  HADDR, HTRANS, HREADY,
    output HSEL, dp_sel, def_hreadyout, def_hresp, err_count
  );
endinterface

// File: rtl/ahb_slave_decoder.sv
// AHB address decoder: one-hot slave select, registered data-phase select and a
// default slave that answers unmapped active transfers with a two-cycle ERROR.
module ahb_slave_decoder #(
  parameter int                SLAVE_NUM = 4,
  parameter int                ADDR_W    = 32,
  parameter int                RGN_W     = 12,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_slave_decoder_if.slave bus
);

  typedef logic [ADDR_W:0] addr_ext_t;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ERR1,
    ST_ERR2
  } def_state_t;

  logic [SLAVE_NUM-1:0] hsel;
  logic                 unmapped;
  logic                 err_start;
  addr_ext_t            addr_ext;
  addr_ext_t            rgn_lo;
  addr_ext_t            rgn_hi;

  logic [SLAVE_NUM:0]   dp_sel_d,        dp_sel_q;
  def_state_t           state_d,         state_q;
  logic                 def_hreadyout_d, def_hreadyout_q;
  logic                 def_hresp_d,     def_hresp_q;
  logic [7:0]           err_count_d,     err_count_q;

  // Region bounds are compared one bit wider than HADDR so the top region cannot wrap to zero.
  assign addr_ext = {1'b0, bus.HADDR};

  // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it
  // holding its old value and no latch is inferred.
  always_comb begin
    hsel   = '0;
    rgn_lo = '0;
    rgn_hi = '0;
    for (int i = 0; i < SLAVE_NUM; i++) begin
      rgn_lo = addr_ext_t'(BASE_ADDR) + (addr_ext_t'(i) << RGN_W);
      rgn_hi = rgn_lo + (addr_ext_t'(1) << RGN_W);
      if ((addr_ext >= rgn_lo) && (addr_ext < rgn_hi)) begin
        hsel[i] = 1'b1;
      end
    end
  end

  assign unmapped  = ~|hsel;
  assign err_start = bus.HREADY && unmapped &&
                     ((bus.HTRANS == TR_NONSEQ) || (bus.HTRANS == TR_SEQ));

  always_comb begin
    dp_sel_d    = bus.HREADY ? {unmapped, hsel} : dp_sel_q;
    state_d     = ST_IDLE;
    err_count_d = err_count_q;

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = err_start ? ST_ERR1 : ST_IDLE;
    endcase

    if ((state_q == ST_ERR2) && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end

    // Outputs are decoded from the next state and registered, keeping HADDR/HTRANS off the response path.
    def_hreadyout_d = (state_d != ST_ERR1);
    def_hresp_d     = (state_d != ST_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_sel_q        <= (SLAVE_NUM+1)'(1) << SLAVE_NUM;
      state_q         <= ST_IDLE;
      def_hreadyout_q <= 1'b1;
      def_hresp_q     <= 1'b0;
      err_count_q     <= '0;
    end else begin
      dp_sel_q        <= dp_sel_d;
      state_q         <= state_d;
      def_hreadyout_q <= def_hreadyout_d;
      def_hresp_q     <= def_hresp_d;
      err_count_q     <= err_count_d;
    end
  end

  assign bus.HSEL          = hsel;
  assign bus.dp_sel        = dp_sel_q;
  assign bus.def_hreadyout = def_hreadyout_q;
  assign bus.def_hresp     = def_hresp_q;
  assign bus.err_count     = err_count_q;

endmodule

// File: tb/tb_ahb_slave_decoder.sv
// Directed bench for ahb_slave_decoder with the default map: four 4 KiB slaves from
// address 0, everything at or above 0x4000 unmapped.
module tb_ahb_slave_decoder;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;

  logic HCLK;
  logic HRESETn;
  int   n_cmp;
  int   n_err;

  ahb_slave_decoder_if #(.SLAVE_NUM(4), .ADDR_W(32)) bus ();

  ahb_slave_decoder #(
    .SLAVE_NUM(4),
    .ADDR_W   (32),
    .RGN_W    (12),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .bus    (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [1:0] trans, input logic ready);
    bus.HADDR  = addr;
    bus.HTRANS = trans;
    bus.HREADY = ready;
    #1;
  endtask

  // Advance one rising edge and settle, so registered outputs are sampled mid-cycle.
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_resp(input string tag, input logic rdy, input logic rsp);
    check({tag, ".hreadyout"}, 32'(bus.def_hreadyout), 32'(rdy));
    check({tag, ".hresp"},     32'(bus.def_hresp),     32'(rsp));
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    HRESETn = 1'b0;
    drive(32'h0000_0000, IDLE, 1'b1);

    // Reset state; HSEL keeps decoding while reset is held.
    tick();
    check("rst.dp_sel", 32'(bus.dp_sel), 32'h10);
    check_resp("rst", 1'b1, 1'b0);
    check("rst.err_count", 32'(bus.err_count), 32'h0);
    check("rst.hsel", 32'(bus.HSEL), 32'h1);
    HRESETn = 1'b1;

    // Mapped NONSEQ to slave 2.
    drive(32'h0000_2004, NONSEQ, 1'b1);
    check("map.hsel", 32'(bus.HSEL), 32'h4);
    tick();
    check("map.dp_sel", 32'(bus.dp_sel), 32'h04);
    check_resp("map", 1'b1, 1'b0);

    // Region edges.
    drive(32'h0000_0FFF, IDLE, 1'b1);
    check("edge.0fff", 32'(bus.HSEL), 32'h1);
    drive(32'h0000_1000, IDLE, 1'b1);
    check("edge.1000", 32'(bus.HSEL), 32'h2);
    drive(32'h0000_3FFF, IDLE, 1'b1);
    check("edge.3fff", 32'(bus.HSEL), 32'h8);
    drive(32'h0000_4000, IDLE, 1'b1);
    check("edge.4000", 32'(bus.HSEL), 32'h0);

    // Unmapped NONSEQ: ERR1, ERR2 (bus stalled during ERR1), then back to IDLE.
    drive(32'h0000_4000, NONSEQ, 1'b1);
    tick();
    check_resp("un.c1", 1'b0, 1'b1);
    check("un.c1.dp_sel", 32'(bus.dp_sel), 32'h10);
    drive(32'h0000_0000, IDLE, 1'b0);
    tick();
    check_resp("un.c2", 1'b1, 1'b1);
    check("un.c2.dp_sel", 32'(bus.dp_sel), 32'h10);
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
    check_resp("un.c3", 1'b1, 1'b0);
    check("un.c3.err_count", 32'(bus.err_count), 32'h1);
    check("un.c3.dp_sel", 32'(bus.dp_sel), 32'h01);

    // Unmapped IDLE then BUSY: zero-wait OKAY from the default slave.
    drive(32'hFFFF_0000, IDLE, 1'b1);
    check("ui.hsel", 32'(bus.HSEL), 32'h0);
    tick();
    check("ui.c1.dp_sel", 32'(bus.dp_sel), 32'h10);
    check_resp("ui.c1", 1'b1, 1'b0);
    tick();
    check_resp("ui.c2", 1'b1, 1'b0);
    drive(32'hFFFF_0000, BUSY, 1'b1);
    tick();
    check_resp("ub.c1", 1'b1, 1'b0);
    check("ub.err_count", 32'(bus.err_count), 32'h1);

    // Back-to-back errors; a mapped address offered while stalled must not load dp_sel.
    drive(32'h0000_5000, NONSEQ, 1'b1);
    tick();
    check_resp("bb.e1", 1'b0, 1'b1);
    drive(32'h0000_1000, NONSEQ, 1'b0);
    tick();
    check_resp("bb.e2", 1'b1, 1'b1);
    check("bb.e2.dp_sel", 32'(bus.dp_sel), 32'h10);
    drive(32'h0000_6000, SEQ, 1'b1);
    tick();
    check_resp("bb.e3", 1'b0, 1'b1);
    check("bb.e3.err_count", 32'(bus.err_count), 32'h2);
    drive(32'h0000_2000, NONSEQ, 1'b0);
    tick();
    check_resp("bb.e4", 1'b1, 1'b1);
    check("bb.e4.dp_sel", 32'(bus.dp_sel), 32'h10);
    drive(32'h0000_2000, NONSEQ, 1'b1);
    tick();
    check_resp("bb.end", 1'b1, 1'b0);
    check("bb.end.err_count", 32'(bus.err_count), 32'h3);
    check("bb.end.dp_sel", 32'(bus.dp_sel), 32'h04);

    // 251 more errors bring the count to 254, then 9 more saturate it.
    for (int k = 0; k < 251; k++) begin
      drive(32'h8000_0000, NONSEQ, 1'b1);
      tick();
      drive(32'h8000_0000, NONSEQ, 1'b0);
      tick();
    end
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
    check("sat.fe", 32'(bus.err_count), 32'hFE);
    for (int k = 0; k < 9; k++) begin
      drive(32'h8000_0000, NONSEQ, 1'b1);
      tick();
      drive(32'h8000_0000, NONSEQ, 1'b0);
      tick();
    end
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
    check("sat.ff", 32'(bus.err_count), 32'hFF);
    check_resp("sat.idle", 1'b1, 1'b0);

    // Reset during ERR1 discards the pending error.
    drive(32'h0001_0000, NONSEQ, 1'b1);
    tick();
    check_resp("rerr.e1", 1'b0, 1'b1);
    HRESETn = 1'b0;
    drive(32'h0000_0000, IDLE, 1'b1);
    tick();
    check_resp("rerr.rst", 1'b1, 1'b0);
    check("rerr.err_count", 32'(bus.err_count), 32'h0);
    check("rerr.dp_sel", 32'(bus.dp_sel), 32'h10);
    HRESETn = 1'b1;
    tick();
    check_resp("rerr.after", 1'b1, 1'b0);
    check("rerr.after.dp_sel", 32'(bus.dp_sel), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahb_slave_decoder.md
AHB_SLAVE_DECODER -- requirements
Module: ahb_slave_decoder

Interface
REQ-001 Param SLAVE_NUM, default 4: number of mapped slaves.
REQ-002 Param ADDR_W, default 32: HADDR width.
REQ-003 Param RGN_W, default 12: log2 of each slave region size.
REQ-004 Param BASE_ADDR, default 32'h0000_0000: start of slave 0 region; slave i occupies [BASE_ADDR + i*2^RGN_W, BASE_ADDR + (i+1)*2^RGN_W - 1].
REQ-005 HCLK  in  1  sole clock; all state updates on rising edge.
REQ-006 HRESETn  in  1  reset, synchronous, active-low.
REQ-007 HADDR  in  ADDR_W  address-phase address.
REQ-008 HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-009 HREADY  in  1  global bus ready; an address phase is accepted when HREADY=1.
REQ-010 HSEL  out  SLAVE_NUM  combinational one-hot address-phase slave select.
REQ-011 dp_sel  out  SLAVE_NUM+1  registered one-hot data-phase select for the slave response mux; bit SLAVE_NUM = default slave.
REQ-012 def_hreadyout  out  1  default-slave HREADYOUT.
REQ-013 def_hresp  out  1  default-slave HRESP (0 OKAY, 1 ERROR).
REQ-014 err_count  out  8  saturating count of completed default-slave ERROR responses.

Function
REQ-015 HSEL[i] SHALL be 1 iff HADDR lies in slave i region, independent of HTRANS and HREADY; at most one bit set.
REQ-016 Address is unmapped when no HSEL bit is set (below BASE_ADDR or at/above BASE_ADDR + SLAVE_NUM*2^RGN_W); no wrap-around in the region arithmetic, computed at ADDR_W+1 bits.
REQ-017 When HREADY=1, dp_sel SHALL load {unmapped, HSEL} on the next edge; when HREADY=0, dp_sel SHALL hold.
REQ-018 dp_sel SHALL always be one-hot; latency from address phase to dp_sel is exactly 1 accepted cycle.
REQ-019 Default slave FSM states: IDLE, ERR1, ERR2.
REQ-020 IDLE: def_hreadyout=1, def_hresp=0.
REQ-021 ERR1: def_hreadyout=0, def_hresp=1; always transitions to ERR2 next cycle.
REQ-022 ERR2: def_hreadyout=1, def_hresp=1.
REQ-023 IDLE or ERR2 -> ERR1 when HREADY=1, HTRANS is NONSEQ or SEQ and address unmapped; otherwise -> IDLE.
REQ-024 Unmapped IDLE or BUSY transfers SHALL receive a zero-wait OKAY (FSM stays/returns to IDLE).
REQ-025 Back-to-back unmapped NONSEQ accepted during ERR2 (HREADY=1) SHALL go ERR2 -> ERR1 with no IDLE cycle.
REQ-026 FSM outputs are registered state decodes; no combinational path from HADDR/HTRANS to def_hreadyout/def_hresp.
REQ-027 err_count SHALL increment by 1 on each ERR2 cycle, saturating at 8'hFF.
REQ-028 Mapped transfers SHALL never change FSM state except via REQ-023 exit to IDLE.

Reset
REQ-029 While HRESETn=0 at an edge: dp_sel = 1<<SLAVE_NUM, FSM = IDLE, def_hreadyout=1, def_hresp=0, err_count=0.
REQ-030 Reset asserted mid-ERR1/ERR2 SHALL return to IDLE at that edge, discarding the pending error; err_count clears.
REQ-031 HSEL is combinational and unaffected by reset.

Verification
REQ-032 Reset: HRESETn=0 one edge -> dp_sel=5'b10000, def_hreadyout=1, def_hresp=0, err_count=0.
REQ-033 Mapped: HADDR=32'h0000_2004, HTRANS=NONSEQ, HREADY=1 -> HSEL=4'b0100 same cycle, dp_sel=5'b00100 next cycle, FSM stays IDLE.
REQ-034 Unmapped NONSEQ: HADDR=32'h0000_4000, HREADY=1 -> cycle+1 def_hreadyout=0/def_hresp=1, cycle+2 1/1, cycle+3 1/0 if bus idle; err_count=1.
REQ-035 Unmapped IDLE transfer at 32'hFFFF_0000 -> dp_sel=5'b10000, def_hreadyout=1, def_hresp=0 every cycle, err_count unchanged.
REQ-036 Two back-to-back unmapped NONSEQ (second accepted in ERR2) -> sequence ERR1,ERR2,ERR1,ERR2; err_count=2; HREADY=0 stall holds dp_sel.
REQ-037 Force 260 unmapped NONSEQ errors -> err_count saturates at 8'hFF; HRESETn=0 during ERR1 -> next cycle IDLE, err_count=0.
